// File: rtl/implication_monitor_pkg.sv
// Shared constants and helpers for the implication window monitor.
package implication_monitor_pkg;

    // Deepest supported window; bounds the per-lane pending shift register.
    localparam int unsigned MAX_DLY_LIMIT = 16;

    // Widest supported failure counter.
    localparam int unsigned CNT_W_LIMIT = 31;

    // Increment v by one, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    // True when the parameter set describes a buildable monitor.
    function automatic bit params_ok(input int unsigned num_ch,
                                     input int unsigned min_dly,
                                     input int unsigned max_dly,
                                     input int unsigned cnt_w);
        return (num_ch >= 1) && (min_dly >= 1) && (min_dly <= max_dly) &&
               (max_dly <= MAX_DLY_LIMIT) && (cnt_w >= 1) && (cnt_w <= CNT_W_LIMIT);
    endfunction

endpackage

// File: rtl/implication_lane.sv
// One monitor channel: pending-attempt shift register, discharge/fail
// resolution, saturating failure counter and sticky flag.
module implication_lane
    import implication_monitor_pkg::*;
#(
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             clr,
    input  logic             ante,
    input  logic             cons,
    output logic             fail,
    output logic             pass,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             pending
);

    // pend_q[a] set: an undischarged attempt of age a cycles.
    logic [MAX_DLY:1] pend_q;
    logic [MAX_DLY:1] pend_d;
    logic             fail_d;
    logic             pass_d;
    logic             sticky_d;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_d;
    logic             elig_any;

    // Next-state: launch, discharge eligible ages on cons, age survivors, resolve.
    always_comb begin
        pend_d    = '0;
        fail_d    = 1'b0;
        pass_d    = 1'b0;
        elig_any  = 1'b0;
        sticky_d  = fail_sticky;
        cnt_d     = fail_cnt;

        for (int unsigned a = MIN_DLY; a <= MAX_DLY; a++) begin
            elig_any = elig_any | pend_q[a];
        end

        if (en) begin
            pend_d[1] = ante;
            for (int unsigned a = 1; a < MAX_DLY; a++) begin
                pend_d[a+1] = pend_q[a] & ~(cons & (a >= MIN_DLY));
            end
            pass_d = cons & elig_any;
            fail_d = pend_q[MAX_DLY] & ~cons;
        end

        if (clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (fail_d) begin
            cnt_d    = CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
            sticky_d = 1'b1;
        end

        pending_d = |pend_d;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_q      <= '0;
            fail        <= 1'b0;
            pass        <= 1'b0;
            fail_sticky <= 1'b0;
            fail_cnt    <= '0;
            pending     <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            fail        <= fail_d;
            pass        <= pass_d;
            fail_sticky <= sticky_d;
            fail_cnt    <= cnt_d;
            pending     <= pending_d;
        end
    end

endmodule

// File: rtl/implication_window_monitor.sv
// Multi-channel "ante |-> ##[MIN_DLY:MAX_DLY] cons" checker with pulse,
// sticky and counter reporting.
module implication_window_monitor
    import implication_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       ante,
    input  logic [NUM_CH-1:0]       cons,
    output logic [NUM_CH-1:0]       fail,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       fail_sticky,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt,
    output logic [NUM_CH-1:0]       pending
);

    // Refuse to build with an illegal window or counter width.
    if (!params_ok(NUM_CH, MIN_DLY, MAX_DLY, CNT_W)) begin : g_bad_params
        $error("implication_window_monitor: illegal parameters NUM_CH=%0d MIN_DLY=%0d MAX_DLY=%0d CNT_W=%0d",
               NUM_CH, MIN_DLY, MAX_DLY, CNT_W);
    end

    // One independent lane per channel; control and clock broadcast.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        implication_lane #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W)
        ) u_lane (
            .CLK         (CLK),
            .RESET       (RESET),
            .en          (en),
            .clr         (clr),
            .ante        (ante[i]),
            .cons        (cons[i]),
            .fail        (fail[i]),
            .pass        (pass[i]),
            .fail_sticky (fail_sticky[i]),
            .fail_cnt    (fail_cnt[i*CNT_W +: CNT_W]),
            .pending     (pending[i])
        );
    end

endmodule

// File: tb/tb_implication_window_monitor.sv
// Directed bench: three monitor instances (window 1..1, 1..3, 2..3) share
// the same stimulus; each scenario checks the instance it targets.
module tb_implication_window_monitor;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic       en    = 1'b1;
    logic       clr   = 1'b0;
    logic [1:0] ante  = 2'b00;
    logic [1:0] cons  = 2'b00;

    logic [1:0] fail_a, pass_a, stk_a, pend_a;
    logic [7:0] cnt_a;
    logic [1:0] fail_b, pass_b, stk_b, pend_b;
    logic [7:0] cnt_b;
    logic [1:0] fail_c, pass_c, stk_c, pend_c;
    logic [7:0] cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    implication_window_monitor #(.NUM_CH(2), .MIN_DLY(1), .MAX_DLY(1), .CNT_W(4)) u_a (
        .CLK(CLK), .RESET(RESET), .en(en), .clr(clr), .ante(ante), .cons(cons),
        .fail(fail_a), .pass(pass_a), .fail_sticky(stk_a), .fail_cnt(cnt_a), .pending(pend_a));

    implication_window_monitor u_b (
        .CLK(CLK), .RESET(RESET), .en(en), .clr(clr), .ante(ante), .cons(cons),
        .fail(fail_b), .pass(pass_b), .fail_sticky(stk_b), .fail_cnt(cnt_b), .pending(pend_b));

    implication_window_monitor #(.NUM_CH(2), .MIN_DLY(2), .MAX_DLY(3), .CNT_W(4)) u_c (
        .CLK(CLK), .RESET(RESET), .en(en), .clr(clr), .ante(ante), .cons(cons),
        .fail(fail_c), .pass(pass_c), .fail_sticky(stk_c), .fail_cnt(cnt_c), .pending(pend_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance into the next cycle; outputs are stable, inputs may be changed.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        ante  = 2'b00;
        cons  = 2'b00;
        tick();
        tick();
        RESET = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_fail_a", 32'(fail_a), 0);
        check("rst_pass_b", 32'(pass_b), 0);
        check("rst_pend_c", 32'(pend_c), 0);
        check("rst_cnt_b",  32'(cnt_b),  0);
        check("rst_stk_a",  32'(stk_a),  0);
        RESET = 1'b1;
        tick();

        // Window 1..1: ante c0, cons c1 -> pass c2, no fail
        ante = 2'b01;
        tick();
        check("t1_pending", 32'(pend_a[0]), 1);
        ante = 2'b00; cons = 2'b01;
        tick();
        check("t1_pass", 32'(pass_a[0]), 1);
        check("t1_nofail", 32'(fail_a[0]), 0);
        cons = 2'b00;
        tick();
        check("t1_pass_drop", 32'(pass_a[0]), 0);
        check("t1_fail_c3", 32'(fail_a[0]), 0);

        // Window 1..1: ante c0, no cons -> fail c2 only
        do_reset();
        ante = 2'b01;
        tick();
        ante = 2'b00;
        tick();
        check("t2_fail", 32'(fail_a[0]), 1);
        check("t2_cnt", 32'(cnt_a[3:0]), 1);
        check("t2_stk", 32'(stk_a[0]), 1);
        tick();
        check("t2_fail_drop", 32'(fail_a[0]), 0);
        check("t2_cnt_hold", 32'(cnt_a[3:0]), 1);

        // Window 1..3, ch1: cons at c3 (age 3) -> pass c4
        do_reset();
        ante = 2'b10;
        tick();
        ante = 2'b00;
        tick();
        tick();
        check("t3_pend_c3", 32'(pend_b[1]), 1);
        cons = 2'b10;
        tick();
        check("t3_pass", 32'(pass_b[1]), 1);
        check("t3_nofail", 32'(fail_b[1]), 0);
        check("t3_pend_c4", 32'(pend_b[1]), 0);
        cons = 2'b00;
        tick();
        check("t3_fail_c5", 32'(fail_b[1]), 0);

        // Window 1..3, ch1: cons at c4 is too late -> fail c4
        do_reset();
        ante = 2'b10;
        tick();
        ante = 2'b00;
        tick();
        tick();
        tick();
        check("t4_fail", 32'(fail_b[1]), 1);
        check("t4_nopass", 32'(pass_b[1]), 0);
        check("t4_cnt1", 32'(cnt_b[7:4]), 1);
        check("t4_cnt0", 32'(cnt_b[3:0]), 0);
        cons = 2'b10;
        tick();
        check("t4_late_nopass", 32'(pass_b[1]), 0);
        cons = 2'b00;

        // Window 2..3: cons at age 1 ignored -> fail c4
        do_reset();
        ante = 2'b01;
        tick();
        ante = 2'b00; cons = 2'b01;
        tick();
        check("t5_nopass", 32'(pass_c[0]), 0);
        cons = 2'b00;
        tick();
        check("t5_fail_c3", 32'(fail_c[0]), 0);
        tick();
        check("t5_fail", 32'(fail_c[0]), 1);

        // Window 2..3: ante c0..c2, cons c3 discharges two, third fails c6
        do_reset();
        ante = 2'b01;
        tick();
        tick();
        tick();
        ante = 2'b00; cons = 2'b01;
        tick();
        check("t6_pass", 32'(pass_c[0]), 1);
        check("t6_nofail_c4", 32'(fail_c[0]), 0);
        check("t6_pend_c4", 32'(pend_c[0]), 1);
        cons = 2'b00;
        tick();
        check("t6_nofail_c5", 32'(fail_c[0]), 0);
        tick();
        check("t6_fail_c6", 32'(fail_c[0]), 1);
        check("t6_cnt", 32'(cnt_c[3:0]), 1);
        tick();
        check("t6_fail_c7", 32'(fail_c[0]), 0);
        check("t6_pend_c7", 32'(pend_c[0]), 0);

        // Saturation on window 1..1: ante c0..c19, fails c2..c21, clr at c20
        do_reset();
        ante = 2'b01;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15) check("t7_cnt14", 32'(cnt_a[3:0]), 14);
            if (c == 16) check("t7_cnt15", 32'(cnt_a[3:0]), 15);
            if (c == 20) begin
                check("t7_cnt_sat", 32'(cnt_a[3:0]), 15);
                check("t7_stk", 32'(stk_a[0]), 1);
                ante = 2'b00;
                clr  = 1'b1;
            end
        end
        tick();
        check("t7_clr_fail", 32'(fail_a[0]), 1);
        check("t7_clr_cnt", 32'(cnt_a[3:0]), 0);
        check("t7_clr_stk", 32'(stk_a[0]), 0);
        clr = 1'b0;
        tick();
        check("t7_post_fail", 32'(fail_a[0]), 0);
        check("t7_post_cnt", 32'(cnt_a[3:0]), 0);

        // en=0 for two cycles kills the outstanding attempt
        do_reset();
        ante = 2'b01;
        tick();
        check("t8_pend_c1", 32'(pend_b[0]), 1);
        ante = 2'b00; en = 1'b0;
        tick();
        check("t8_pend_c2", 32'(pend_b[0]), 0);
        tick();
        en = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            tick();
            check("t8_nofail", 32'(fail_b[0]), 0);
            check("t8_nopass", 32'(pass_b[0]), 0);
        end

        // Asynchronous reset mid-cycle discards the attempt
        do_reset();
        ante = 2'b01;
        tick();
        ante = 2'b00;
        check("t9_pend_pre", 32'(pend_b[0]), 1);
        #2 RESET = 1'b0;
        #1;
        check("t9_pend_rst", 32'(pend_b[0]), 0);
        check("t9_fail_rst", 32'(fail_b), 0);
        check("t9_cnt_rst", 32'(cnt_b), 0);
        #1 RESET = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            tick();
            check("t9_nofail", 32'(fail_b[0]), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
